// File: rtl/instr_decode_stage_if.sv
// Fetch-to-decode handshake plus the registered decoded-field bundle.
// The decode stage uses the slave modport; the fetch/consumer side uses master.
interface instr_decode_stage_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int IMM_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [5:0]         opcode;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [4:0]         shamt;
    logic [5:0]         funct;
    logic [IMM_W-1:0]   imm16;
    logic               imm_neg;
    logic [25:0]        target26;
    logic               is_rtype;
    logic               is_jump;
    logic               is_itype;
    logic [4:0]         wr_reg;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rs, rt, rd, shamt, funct,
               imm16, imm_neg, target26, is_rtype, is_jump, is_itype, wr_reg
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, rs, rt, rd, shamt, funct,
               imm16, imm_neg, target26, is_rtype, is_jump, is_itype, wr_reg
    );
endinterface

// File: rtl/instr_decode_stage.sv
// IF/ID stage: 2-entry skid buffer (main + skid) with fields decoded on the way
// into main, so every output is a flop and in_ready never depends on out_ready.
module instr_decode_stage #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int IMM_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    instr_decode_stage_if.slave   bus
);
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [5:0]       opcode;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       shamt;
        logic [5:0]       funct;
        logic [IMM_W-1:0] imm16;
        logic             imm_neg;
        logic [25:0]      target26;
        logic             is_rtype;
        logic             is_jump;
        logic             is_itype;
        logic [4:0]       wr_reg;
    } fields_t;

    function automatic fields_t decode(input logic [INSTR_W-1:0] w, input logic [PC_W-1:0] pc);
        fields_t f;
        f.pc       = pc;
        f.opcode   = w[31:26];
        f.rs       = w[25:21];
        f.rt       = w[20:16];
        f.rd       = w[15:11];
        f.shamt    = w[10:6];
        f.funct    = w[5:0];
        f.imm16    = w[IMM_W-1:0];
        f.imm_neg  = w[IMM_W-1];
        f.target26 = w[25:0];
        f.is_rtype = (w[31:26] == 6'h00);
        f.is_jump  = (w[31:26] == 6'h02) || (w[31:26] == 6'h03);
        f.is_itype = ~f.is_rtype & ~f.is_jump;
        if (f.is_rtype)
            f.wr_reg = w[15:11];
        else if (w[31:26] == 6'h03)
            f.wr_reg = 5'd31;
        else
            f.wr_reg = w[20:16];
        return f;
    endfunction

    logic               main_valid_q, main_valid_d;
    fields_t            main_q, main_d;
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

    logic in_xfer;
    logic main_free;

    assign bus.in_ready = ~skid_valid_q & ~rst;
    assign in_xfer      = bus.in_valid & bus.in_ready;
    // Main may take new data when empty or when its content leaves this cycle.
    assign main_free    = ~main_valid_q | bus.out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = decode(skid_instr_q, skid_pc_q);
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_valid_d = 1'b1;
                main_d       = decode(bus.in_instr, bus.in_pc);
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_instr_d = bus.in_instr;
            skid_pc_d    = bus.in_pc;
        end

        // Fields may stay stale after a flush; only the valid bits are dropped.
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign bus.out_valid = main_valid_q;
    assign bus.out_pc    = main_q.pc;
    assign bus.opcode    = main_q.opcode;
    assign bus.rs        = main_q.rs;
    assign bus.rt        = main_q.rt;
    assign bus.rd        = main_q.rd;
    assign bus.shamt     = main_q.shamt;
    assign bus.funct     = main_q.funct;
    assign bus.imm16     = main_q.imm16;
    assign bus.imm_neg   = main_q.imm_neg;
    assign bus.target26  = main_q.target26;
    assign bus.is_rtype  = main_q.is_rtype;
    assign bus.is_jump   = main_q.is_jump;
    assign bus.is_itype  = main_q.is_itype;
    assign bus.wr_reg    = main_q.wr_reg;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode vectors, skid/stall, flush,
// an 8-instruction stream under a fixed out_ready pattern, and mid-stream reset.
module tb_instr_decode_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    instr_decode_stage_if bus ();

    instr_decode_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    initial begin
        logic [15:0] rdy_pat;
        int sent;
        int rcv;
        int cyc;
        logic in_fire;
        logic out_fire;

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_opcode", {26'd0, bus.opcode}, 32'd0);
        chk("rst_flags", {29'd0, bus.is_rtype, bus.is_jump, bus.is_itype}, 32'd0);

        rst = 1'b0;
        step();
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // lw r2,-4(r1)
        push(32'h8C22FFFC, 32'h0000_0040);
        step();
        chk("lw_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lw_opcode", {26'd0, bus.opcode}, 32'h23);
        chk("lw_rs", {27'd0, bus.rs}, 32'd1);
        chk("lw_rt", {27'd0, bus.rt}, 32'd2);
        chk("lw_imm16", {16'd0, bus.imm16}, 32'hFFFC);
        chk("lw_imm_neg", {31'd0, bus.imm_neg}, 32'd1);
        chk("lw_flags", {29'd0, bus.is_rtype, bus.is_jump, bus.is_itype}, 32'b001);
        chk("lw_wr_reg", {27'd0, bus.wr_reg}, 32'd2);
        chk("lw_pc", bus.out_pc, 32'h40);

        // add r3,r1,r2
        push(32'h00221820, 32'h0000_0044);
        step();
        chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("add_rs_rt_rd", {17'd0, bus.rs, bus.rt, bus.rd}, {17'd0, 5'd1, 5'd2, 5'd3});
        chk("add_shamt", {27'd0, bus.shamt}, 32'd0);
        chk("add_funct", {26'd0, bus.funct}, 32'h20);
        chk("add_flags", {29'd0, bus.is_rtype, bus.is_jump, bus.is_itype}, 32'b100);
        chk("add_wr_reg", {27'd0, bus.wr_reg}, 32'd3);
        chk("add_imm_neg", {31'd0, bus.imm_neg}, 32'd0);
        chk("add_pc", bus.out_pc, 32'h44);

        // jal 0x10
        push(32'h0C000010, 32'h0000_0048);
        step();
        chk("jal_opcode", {26'd0, bus.opcode}, 32'h03);
        chk("jal_target", {6'd0, bus.target26}, 32'h10);
        chk("jal_flags", {29'd0, bus.is_rtype, bus.is_jump, bus.is_itype}, 32'b010);
        chk("jal_wr_reg", {27'd0, bus.wr_reg}, 32'd31);

        bus.in_valid = 1'b0;
        step();
        chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Stall and skid: A then B with downstream blocked
        bus.out_ready = 1'b0;
        push(32'h20010005, 32'h0000_0100);
        step();
        chk("stall_a_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_a_in_ready", {31'd0, bus.in_ready}, 32'd1);
        push(32'h20020007, 32'h0000_0104);
        step();
        chk("skid_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_hold_pc", bus.out_pc, 32'h100);
        chk("stall_hold_rt", {27'd0, bus.rt}, 32'd1);
        push(32'hDEADBEEF, 32'h0000_0DEA);
        step();
        chk("stall_hold2_pc", bus.out_pc, 32'h100);
        chk("stall_hold2_imm", {16'd0, bus.imm16}, 32'h0005);
        chk("skid_full2_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("release_b_pc", bus.out_pc, 32'h104);
        chk("release_b_rt", {27'd0, bus.rt}, 32'd2);
        chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("release_empty", {31'd0, bus.out_valid}, 32'd0);

        // Flush with both entries full and in_valid high
        bus.out_ready = 1'b0;
        push(32'h20030001, 32'h0000_0200);
        step();
        push(32'h20040002, 32'h0000_0204);
        step();
        chk("pre_flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
        push(32'h20060004, 32'h0000_0208);
        flush = 1'b1;
        step();
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        // Instruction accepted during a flush is dropped
        push(32'h20070006, 32'h0000_020C);
        step();
        chk("flush_drop_valid", {31'd0, bus.out_valid}, 32'd0);
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        push(32'h20050003, 32'h0000_0210);
        step();
        chk("post_flush_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("post_flush_pc", bus.out_pc, 32'h210);
        bus.in_valid = 1'b0;
        step();
        chk("post_flush_empty", {31'd0, bus.out_valid}, 32'd0);

        // 8-instruction stream, fixed out_ready pattern, expected PC/imm by index
        rdy_pat = 16'b1011_0010_1110_0101;
        sent = 0;
        rcv  = 0;
        cyc  = 0;
        while (rcv < 8 && cyc < 100) begin
            bus.out_ready = rdy_pat[cyc % 16];
            if (sent < 8) push(32'h2008_0000 | sent, 32'h300 + 4 * sent);
            else bus.in_valid = 1'b0;
            in_fire  = bus.in_valid & bus.in_ready;
            out_fire = bus.out_valid & bus.out_ready;
            if (out_fire) begin
                chk($sformatf("stream_pc%0d", rcv), bus.out_pc, 32'h300 + 4 * rcv);
                chk($sformatf("stream_imm%0d", rcv), {16'd0, bus.imm16}, rcv);
                rcv++;
            end
            if (in_fire) sent++;
            step();
            cyc++;
        end
        chk("stream_all_received", rcv, 32'd8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("stream_no_dup", {31'd0, bus.out_valid}, 32'd0);

        // Reset mid-stall (flush asserted too: reset must win and zero fields)
        bus.out_ready = 1'b0;
        push(32'h0C000010, 32'h0000_0400);
        step();
        push(32'h00221820, 32'h0000_0404);
        step();
        bus.in_valid = 1'b0;
        rst   = 1'b1;
        flush = 1'b1;
        step();
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("midrst_pc", bus.out_pc, 32'd0);
        chk("midrst_fields", {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}, 32'd0);
        chk("midrst_target_wr", {1'b0, bus.target26, bus.wr_reg}, 32'd0);
        chk("midrst_flags", {28'd0, bus.imm_neg, bus.is_rtype, bus.is_jump, bus.is_itype}, 32'd0);
        rst   = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("after_midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("after_midrst_empty", {31'd0, bus.out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
